// File: rtl/qam_pkg.sv
// Shared definitions for the 16QAM stream controller: FSM state encoding,
// default FIFO geometry and the demapped symbol width.
package qam_pkg;
  localparam int SYM_W           = 4;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_START_LEVEL = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;
endpackage

// File: rtl/qam_occ_counter.sv
// Up/down occupancy counter shadowing the symbol FIFO fill level; exposes
// both the current and the next count so callers can act on the post-edge value.
module qam_occ_counter #(
  parameter int DEPTH = 16,
  parameter int OCC_W = 5
) (
  input  logic             dclk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [OCC_W-1:0] occ_o,
  output logic [OCC_W-1:0] occ_next_o
);
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_inc, do_dec;

  // Guards keep the count inside 0..DEPTH even if a caller misbehaves.
  always_comb begin
    do_inc = inc_i && (occ_q < OCC_W'(DEPTH));
    do_dec = dec_i && (occ_q != '0);
    occ_d  = occ_q;
    if (do_inc && !do_dec) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (do_dec && !do_inc) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ_o      = occ_q;
  assign occ_next_o = occ_d;
endmodule

// File: rtl/qam_stream_controller.sv
// Sequences demapped symbols into the symbol FIFO and schedules reads toward
// the consumer. Optional saturating drop counter: define QAM_DROP_COUNT_EN.
module qam_stream_controller
  import qam_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int START_LEVEL = DEF_START_LEVEL,
  parameter int OCC_W       = 5
) (
  input  logic             dclk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sym_valid,
  input  logic             out_ready,
  input  logic             fifo_wfull,
  input  logic             fifo_rdempty,
  output logic             write_enable,
  output logic             read_enable,
  output logic             out_valid,
  output logic             available,
  output logic             complete,
  output logic             overflow,
  output logic [OCC_W-1:0] occupancy,
  output logic [7:0]       drop_count,
  output logic [2:0]       dbg_state
);
  // Handshake: write_enable/read_enable are single-cycle requests that the
  // FIFO honours on the same rising edge; out_valid marks FIFO q one cycle
  // after each read request, with no backpressure on that data path.
  state_t           state_q, state_d;
  logic [OCC_W-1:0] occ, occ_next;
  logic             out_valid_q, available_q, overflow_q;
  logic             wr_phase, rd_phase, drop_evt, start_evt;

  qam_occ_counter #(
    .DEPTH (DEPTH),
    .OCC_W (OCC_W)
  ) u_occ (
    .dclk       (dclk),
    .reset      (reset),
    .inc_i      (write_enable),
    .dec_i      (read_enable),
    .occ_o      (occ),
    .occ_next_o (occ_next)
  );

  always_comb begin
    wr_phase     = (state_q == PRIME) || (state_q == STREAM);
    rd_phase     = (state_q == STREAM) || (state_q == DRAIN);
    write_enable = sym_valid && wr_phase && (occ < OCC_W'(DEPTH)) && !fifo_wfull;
    read_enable  = out_ready && rd_phase && (occ != '0) && !fifo_rdempty;
    drop_evt     = sym_valid && wr_phase && !write_enable;
    start_evt    = (state_q == IDLE) && enable;
  end

  // Disable takes priority over the fill-level transitions so a stop request
  // is never lost behind a PRIME/STREAM handover.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (enable) state_d = PRIME;
      PRIME: begin
        if (!enable) state_d = DRAIN;
        else if (occ_next >= OCC_W'(START_LEVEL)) state_d = STREAM;
      end
      STREAM: begin
        if (!enable) state_d = DRAIN;
        else if (occ_next == '0) state_d = PRIME;
      end
      DRAIN:  if (occ_next == '0) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      available_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= read_enable;
      available_q <= (occ_next >= OCC_W'(START_LEVEL));
      if (start_evt) overflow_q <= 1'b0;
      else if (drop_evt) overflow_q <= 1'b1;
    end
  end

`ifdef QAM_DROP_COUNT_EN
  logic [7:0] drop_q;
  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      drop_q <= 8'd0;
    end else if (start_evt) begin
      drop_q <= 8'd0;
    end else if (drop_evt && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end
  assign drop_count = drop_q;
`else
  assign drop_count = 8'd0;
`endif

  assign out_valid = out_valid_q;
  assign available = available_q;
  assign overflow  = overflow_q;
  assign complete  = (state_q == DONE);
  assign occupancy = occ;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_qam_stream_controller.sv
// Randomized and directed bench for qam_stream_controller against a
// cycle-level reference model of the controller rules and the FIFO flags.
module tb_qam_stream_controller;
  import qam_pkg::*;
  localparam int DEPTH = 16;
  localparam int START = 4;

  logic       dclk, reset, enable, sym_valid, out_ready, fifo_wfull, fifo_rdempty;
  logic       write_enable, read_enable, out_valid, available, complete, overflow;
  logic [4:0] occupancy;
  logic [7:0] drop_count;
  logic [2:0] dbg_state;

  qam_stream_controller dut (
    .dclk(dclk), .reset(reset), .enable(enable), .sym_valid(sym_valid),
    .out_ready(out_ready), .fifo_wfull(fifo_wfull), .fifo_rdempty(fifo_rdempty),
    .write_enable(write_enable), .read_enable(read_enable), .out_valid(out_valid),
    .available(available), .complete(complete), .overflow(overflow),
    .occupancy(occupancy), .drop_count(drop_count), .dbg_state(dbg_state)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  state_t m_state;
  int     m_occ, m_drop;
  logic   m_ov, m_av, m_ovf;
  logic   exp_we, exp_re, obs_we, obs_re;

  logic [21:0] dut_vec, mdl_vec;
  assign dut_vec = {obs_we, obs_re, out_valid, available, complete, overflow,
                    occupancy, drop_count, dbg_state};
  assign mdl_vec = {exp_we, exp_re, m_ov, m_av, (m_state == DONE), m_ovf,
                    5'(m_occ), 8'(m_drop), m_state};

  task automatic model_clear();
    m_state = IDLE; m_occ = 0; m_drop = 0;
    m_ov = 0; m_av = 0; m_ovf = 0;
    exp_we = 0; exp_re = 0; obs_we = 0; obs_re = 0;
  endtask

  task automatic do_reset();
    sym_valid = 0; out_ready = 0; enable = 0; fifo_wfull = 0; fifo_rdempty = 1;
    reset = 1;
    model_clear();
    repeat (2) @(posedge dclk);
    @(negedge dclk);
    reset = 0;
    @(posedge dclk);
    #1;
  endtask

  // One clock: drive inputs, sample the combinational requests on the falling
  // edge, then advance the model at the rising edge. Called at posedge+1.
  task automatic tick(input logic sv, input logic rdy, input logic en,
                      input logic ff, input logic fe);
    logic   can_wr, can_rd, drop_evt;
    int     nocc;
    state_t ns;
    sym_valid = sv; out_ready = rdy; enable = en;
    fifo_wfull   = (m_occ >= DEPTH) || ff;
    fifo_rdempty = (m_occ == 0) || fe;
    can_wr   = (m_state == PRIME) || (m_state == STREAM);
    can_rd   = (m_state == STREAM) || (m_state == DRAIN);
    exp_we   = sv && can_wr && (m_occ < DEPTH) && !fifo_wfull;
    exp_re   = rdy && can_rd && (m_occ != 0) && !fifo_rdempty;
    drop_evt = sv && can_wr && !exp_we;
    nocc     = m_occ + (exp_we ? 1 : 0) - (exp_re ? 1 : 0);
    ns = m_state;
    case (m_state)
      IDLE:   if (en) ns = PRIME;
      PRIME:  if (!en) ns = DRAIN; else if (nocc >= START) ns = STREAM;
      STREAM: if (!en) ns = DRAIN; else if (nocc == 0) ns = PRIME;
      DRAIN:  if (nocc == 0) ns = DONE;
      default: ns = IDLE;
    endcase
    @(negedge dclk);
    obs_we = write_enable;
    obs_re = read_enable;
    @(posedge dclk);
    if (m_state == IDLE && en) begin
      m_ovf = 0; m_drop = 0;
    end
    if (drop_evt) begin
      m_ovf = 1;
`ifdef QAM_DROP_COUNT_EN
      if (m_drop < 255) m_drop++;
`endif
    end
    m_ov = exp_re; m_av = (nocc >= START); m_occ = nocc; m_state = ns;
    #1;
  endtask

  task automatic test_reset();
    reset = 1; sym_valid = 1; out_ready = 1; enable = 1;
    fifo_wfull = 0; fifo_rdempty = 0;
    #2;
    checks++;
    if ({write_enable, read_enable, out_valid, available, complete, overflow,
         occupancy, drop_count, dbg_state} !== 22'd0) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=0", {write_enable, read_enable, out_valid,
               available, complete, overflow, occupancy, drop_count, dbg_state});
    end
    do_reset();
    checks++;
    if ({out_valid, available, complete, overflow, occupancy, drop_count, dbg_state} !== 20'd0) begin
      errors++;
      $display("FAIL reset_release got=%h exp=0", {out_valid, available, complete,
               overflow, occupancy, drop_count, dbg_state});
    end
  endtask

  task automatic test_prime_stream();
    int first_rd = -1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick(1, 1, 1, 0, 0);
      if (obs_re && first_rd < 0) first_rd = i;
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        $display("FAIL prime_stream cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (first_rd !== 5 || occupancy !== 5'd4 || available !== 1'b1) begin
      errors++;
      $display("FAIL prime_first_read rd=%0d occ=%0d avail=%b exp rd=5 occ=4 avail=1",
               first_rd, occupancy, available);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 21; i++) begin
      tick(1, 0, 1, 0, 0);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        $display("FAIL overflow cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (occupancy !== 5'd16 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_final occ=%0d ovf=%b exp occ=16 ovf=1", occupancy, overflow);
    end
    checks++;
`ifdef QAM_DROP_COUNT_EN
    if (drop_count !== 8'd4) begin
      errors++;
      $display("FAIL drop_count got=%0d exp=4", drop_count);
    end
`else
    if (drop_count !== 8'd0) begin
      errors++;
      $display("FAIL drop_count got=%0d exp=0", drop_count);
    end
`endif
  endtask

  task automatic test_reenable_clears();
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, 0, 0, 0);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        $display("FAIL reenable_drain cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec);
      end
    end
    tick(0, 0, 1, 0, 0);
    checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0 || dbg_state !== 3'(PRIME)) begin
      errors++;
      $display("FAIL reenable_clear ovf=%b drop=%0d st=%0d exp 0 0 %0d",
               overflow, drop_count, dbg_state, PRIME);
    end
  endtask

  task automatic test_underflow();
    int reads = 0;
    do_reset();
    for (int i = 0; i < 6; i++) tick(1, 1, 1, 0, 0);
    tick(0, 1, 1, 0, 0);
    checks++;
    if (occupancy !== 5'd3 || dbg_state !== 3'(STREAM)) begin
      errors++;
      $display("FAIL underflow_setup occ=%0d st=%0d exp occ=3 st=%0d", occupancy, dbg_state, STREAM);
    end
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 1, 0, 0);
      if (obs_re) reads++;
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        $display("FAIL underflow cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (reads !== 3 || dbg_state !== 3'(PRIME)) begin
      errors++;
      $display("FAIL underflow_final reads=%0d st=%0d exp reads=3 st=%0d", reads, dbg_state, PRIME);
    end
  endtask

  task automatic test_drain();
    int reads = 0, writes = 0, pulses = 0;
    do_reset();
    for (int i = 0; i < 6; i++) tick(1, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(i != 0, 1, (i >= 2 && i <= 4), 0, 0);
      if (obs_re) reads++;
      if (obs_we) writes++;
      if (complete) pulses++;
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        $display("FAIL drain cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (reads !== 5 || writes !== 0 || pulses !== 1 || dbg_state !== 3'(IDLE)) begin
      errors++;
      $display("FAIL drain_final rd=%0d wr=%0d cmpl=%0d st=%0d exp 5 0 1 0",
               reads, writes, pulses, dbg_state);
    end
  endtask

  task automatic test_prime_abort();
    int pulses = 0;
    do_reset();
    tick(0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 0, 0, 0);
      if (complete) pulses++;
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        $display("FAIL prime_abort cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL prime_abort_pulse got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 8; i++) tick(1, 0, 1, 0, 0);
    checks++;
    if (occupancy !== 5'd7 || dbg_state !== 3'(STREAM)) begin
      errors++;
      $display("FAIL midreset_setup occ=%0d st=%0d exp occ=7 st=%0d", occupancy, dbg_state, STREAM);
    end
    sym_valid = 1; out_ready = 1; enable = 1;
    #2 reset = 1;
    #1;
    checks++;
    if ({write_enable, read_enable, out_valid, available, complete, overflow,
         occupancy, drop_count, dbg_state} !== 22'd0) begin
      errors++;
      $display("FAIL midreset got=%h exp=0", {write_enable, read_enable, out_valid,
               available, complete, overflow, occupancy, drop_count, dbg_state});
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
           $urandom_range(0, 19) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_prime_stream();
    test_overflow();
    test_reenable_clears();
    test_underflow();
    test_drain();
    test_prime_abort();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/qam_stream_controller.md
Name: qam_stream_controller

Overview:
- Single-clock controller that sequences the 16QAM demapper output into the symbol FIFO and schedules reads toward the downstream consumer.
- Gates FIFO writes on per-symbol strobes, tracks occupancy internally, and primes to a start level before streaming.
- Handles rebuffering on underflow and drains the FIFO cleanly when the stream is disabled.
- Sits between the demapper datapath and the FIFO read/write ports, in place of ad-hoc enable logic.

Parameters:
- DEPTH, 16, FIFO capacity in 4-bit symbols.
- START_LEVEL, 4, occupancy required before streaming begins; legal range 1..DEPTH.
- OCC_W, 5, occupancy counter width; must hold DEPTH, i.e. at least clog2(DEPTH+1).

Ports:
- dclk  in  1  data clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  stream enable, level-sensitive.
- sym_valid  in  1  one-cycle strobe (dclk domain) per demapped symbol.
- out_ready  in  1  downstream can accept a symbol this cycle.
- fifo_wfull  in  1  FIFO full flag.
- fifo_rdempty  in  1  FIFO empty flag.
- write_enable  out  1  FIFO write request (combinational).
- read_enable  out  1  FIFO read request (combinational).
- out_valid  out  1  FIFO q valid; read_enable delayed by 1 cycle.
- available  out  1  registered; 1 when occ >= START_LEVEL.
- complete  out  1  one-cycle pulse when drain finishes.
- overflow  out  1  sticky dropped-symbol flag.
- occupancy  out  OCC_W  internal occupancy count.
- drop_count  out  8  saturating drop counter; feature-dependent.

Behaviour:
- Reset, asynchronous:
  - State is IDLE; occ = 0.
  - out_valid, available, complete, overflow and drop_count are 0.
  - write_enable and read_enable evaluate to 0 because the state is IDLE.
- FSM states: IDLE, PRIME, STREAM, DRAIN, DONE.
  - IDLE -> PRIME when enable = 1. This transition also clears overflow and drop_count.
  - PRIME -> STREAM when the next occ >= START_LEVEL.
  - PRIME -> DRAIN when enable = 0.
  - STREAM -> PRIME when the next occ = 0 and enable = 1 (underflow, rebuffer).
  - STREAM -> DRAIN when enable = 0.
  - DRAIN -> DONE when the next occ = 0.
  - DONE asserts complete for exactly 1 cycle, then goes to IDLE.
- Write rule:
  - write_enable = sym_valid & (state is PRIME or STREAM) & (occ < DEPTH) & ~fifo_wfull.
  - A sym_valid in PRIME or STREAM that is blocked by full sets overflow; the symbol is dropped.
  - sym_valid in IDLE, DRAIN or DONE is ignored and does not count as overflow.
- Read rule:
  - read_enable = out_ready & (state is STREAM or DRAIN) & (occ != 0) & ~fifo_rdempty.
  - No reads occur in PRIME.
- Occupancy:
  - occ increments on write only, decrements on read only, and is unchanged when both happen in the same cycle.
  - occ never exceeds DEPTH and never goes below 0.
- Latency:
  - out_valid is high exactly 1 cycle after each read_enable, matching the FIFO read latency.
  - available reflects the occ value after the current edge.
- Boundary cases:
  - enable dropped in PRIME with occ = 0: DRAIN then DONE on consecutive cycles, and complete still pulses.
  - enable re-asserted during DRAIN is ignored until IDLE.
  - Reset mid-operation aborts immediately. The FIFO shares the reset (aclr), so occ = 0 stays consistent with it.

Optional Feature:
- Macro: QAM_DROP_COUNT_EN.
- Defined:
  - drop_count increments on each overflow event and saturates at 255.
  - Cleared on reset and on IDLE -> PRIME.
- Undefined: drop_count is tied to 0 and no counter logic is synthesized. overflow is unaffected either way.

Decomposition:
- Shared package qam_pkg holds:
  - the state enum (IDLE, PRIME, STREAM, DRAIN, DONE);
  - the default DEPTH and START_LEVEL constants;
  - the symbol width constant, 4.
- One natural sub-module, qam_occ_counter: the up/down occupancy counter with saturation guards, instantiated once.

Test Plan:
- Reset while streaming with occ = 7: all outputs are 0 within the same cycle and the state is IDLE.
- enable = 1, sym_valid every cycle, out_ready = 1: no read_enable until occ = 4.
  - available rises with the STREAM entry.
  - From then on, reads and writes occur in the same cycle and occ holds at 4.
- out_ready = 0, 20 strobes: occ stops at 16 and write_enable is low while full.
  - overflow = 1.
  - drop_count = 4 with QAM_DROP_COUNT_EN defined.
- In STREAM with occ = 3, stop strobes with out_ready = 1:
  - 3 reads occur, occ reaches 0 and the state returns to PRIME;
  - 1 cycle after each read, out_valid = 1.
- Deassert enable with occ = 5 and out_ready = 1:
  - 5 reads occur, then complete pulses for 1 cycle and the state is IDLE;
  - strobes during DRAIN cause no writes.
- Re-enable after DONE: overflow and drop_count are cleared on PRIME entry.
